// File: rtl/alu_issue_if.sv
// Handshake and payload bundle between register-file read, the issue stage and the ALU.
// The master side is the surrounding pipeline; the slave side is the issue stage itself.
interface alu_issue_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [3:0]      alu_control;
   logic [XLEN-1:0] in1;
   logic [XLEN-1:0] in2;
   logic [4:0]      rd_addr;
   logic            reg_write;
   logic            mem_read;
   logic            mem_write;
   logic [XLEN-1:0] store_data;
   logic            branch;
   logic            branch_inv;
   logic            illegal;

   modport master (
      output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
      input  in_ready, out_valid, alu_control, in1, in2, rd_addr, reg_write,
             mem_read, mem_write, store_data, branch, branch_inv, illegal
   );

   modport slave (
      input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
      output in_ready, out_valid, alu_control, in1, in2, rd_addr, reg_write,
             mem_read, mem_write, store_data, branch, branch_inv, illegal
   );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32 decode/issue stage: decodes the instruction, forms ALU operands and control,
// and holds the result in one valid/ready pipeline register with stall and flush.
module alu_issue_stage #(
   parameter int XLEN = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_issue_if.slave    bus
);

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SLL  = 4'b0011,
      ALU_SUB  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_MUL  = 4'b0110,
      ALU_XOR  = 4'b0111,
      ALU_SLTU = 4'b1000
   } alu_op_e;

   typedef struct packed {
      alu_op_e         ctl;
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [4:0]      rd;
      logic            rw;
      logic            mr;
      logic            mw;
      logic [XLEN-1:0] sd;
      logic            br;
      logic            bi;
      logic            ill;
   } issue_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;
   logic            bad;
   issue_t          dec, held;
   logic            held_valid;
   logic            capture;

   assign opcode = bus.instr[6:0];
   assign funct3 = bus.instr[14:12];
   assign funct7 = bus.instr[31:25];
   assign imm_i  = XLEN'($signed(bus.instr[31:20]));
   assign imm_s  = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
   assign imm_u  = XLEN'($signed({bus.instr[31:12], 12'b0}));
   assign shamt  = XLEN'(bus.instr[24:20]);

   always_comb begin
      // NOTE: every field gets a default before the case so no path leaves a latch.
      dec       = issue_t'('0);
      dec.ctl   = ALU_ADD;
      dec.op1   = bus.rs1_data;
      dec.rd    = bus.instr[11:7];
      bad       = 1'b0;
      unique case (opcode)
         OPC_OP: begin
            dec.op2 = bus.rs2_data;
            dec.rw  = 1'b1;
            unique case ({funct7, funct3})
               {7'b0000000, 3'b000}: dec.ctl = ALU_ADD;
               {7'b0000000, 3'b001}: dec.ctl = ALU_SLL;
               {7'b0000000, 3'b011}: dec.ctl = ALU_SLTU;
               {7'b0000000, 3'b100}: dec.ctl = ALU_XOR;
               {7'b0000000, 3'b101}: dec.ctl = ALU_SRL;
               {7'b0000000, 3'b110}: dec.ctl = ALU_OR;
               {7'b0000000, 3'b111}: dec.ctl = ALU_AND;
               {7'b0100000, 3'b000}: dec.ctl = ALU_SUB;
               {7'b0000001, 3'b000}: dec.ctl = ALU_MUL;
               default:              bad     = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            dec.op2 = imm_i;
            dec.rw  = 1'b1;
            unique case (funct3)
               3'b000: dec.ctl = ALU_ADD;
               3'b011: dec.ctl = ALU_SLTU;
               3'b100: dec.ctl = ALU_XOR;
               3'b110: dec.ctl = ALU_OR;
               3'b111: dec.ctl = ALU_AND;
               3'b001: begin dec.ctl = ALU_SLL; dec.op2 = shamt; bad = (funct7 != 7'b0); end
               3'b101: begin dec.ctl = ALU_SRL; dec.op2 = shamt; bad = (funct7 != 7'b0); end
               default: bad = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            dec.op2 = imm_i;
            dec.mr  = 1'b1;
            dec.rw  = 1'b1;
            bad     = (funct3 != 3'b010);
         end
         OPC_STORE: begin
            dec.op2 = imm_s;
            dec.mw  = 1'b1;
            dec.sd  = bus.rs2_data;
            bad     = (funct3 != 3'b010);
         end
         OPC_BRANCH: begin
            dec.op2 = bus.rs2_data;
            dec.br  = 1'b1;
            dec.bi  = funct3[0];
            unique case (funct3)
               3'b000, 3'b001: dec.ctl = ALU_SUB;
               3'b110, 3'b111: dec.ctl = ALU_SLTU;
               default:        bad     = 1'b1;
            endcase
         end
         OPC_LUI:   begin dec.op1 = '0;     dec.op2 = imm_u; dec.rw = 1'b1; end
         OPC_AUIPC: begin dec.op1 = bus.pc; dec.op2 = imm_u; dec.rw = 1'b1; end
         default:   bad = 1'b1;
      endcase

      // Unsupported encodings still issue, but as an inert ADD of zeros.
      if (bad) begin
         dec     = issue_t'('0);
         dec.ctl = ALU_ADD;
         dec.rd  = bus.instr[11:7];
         dec.ill = 1'b1;
      end
      if (dec.rd == 5'd0) dec.rw = 1'b0;
   end

   assign bus.in_ready = !held_valid || bus.out_ready;
   assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_valid <= 1'b0;
         held       <= issue_t'('0);
         held.ctl   <= ALU_ADD;
      end else if (bus.flush) begin
         held_valid <= 1'b0;
      end else if (capture) begin
         // NOTE: registered state uses non-blocking assignments so all flops update together.
         held_valid <= 1'b1;
         held       <= dec;
      end else if (bus.out_ready) begin
         held_valid <= 1'b0;
      end
   end

   assign bus.out_valid   = held_valid;
   assign bus.alu_control = held.ctl;
   assign bus.in1         = held.op1;
   assign bus.in2         = held.op2;
   assign bus.rd_addr     = held.rd;
   assign bus.reg_write   = held.rw;
   assign bus.mem_read    = held.mr;
   assign bus.mem_write   = held.mw;
   assign bus.store_data  = held.sd;
   assign bus.branch      = held.br;
   assign bus.branch_inv  = held.bi;
   assign bus.illegal     = held.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized self-checking bench for alu_issue_stage: a mnemonic-level reference model
// and a one-deep occupancy model predict every output each cycle.
module tb_alu_issue_stage;

   typedef struct {
      logic [3:0]  ctl;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [31:0] sd;
      logic        br;
      logic        bi;
      logic        ill;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   logic m_vld;
   exp_t m_op;

   alu_issue_if #(.XLEN(32)) bus ();

   alu_issue_stage #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] code_of(input string m);
      case (m)
         "and":   return 4'b0000;
         "or":    return 4'b0001;
         "add":   return 4'b0010;
         "sub":   return 4'b0100;
         "sltu":  return 4'b1000;
         "sll":   return 4'b0011;
         "srl":   return 4'b0101;
         "mul":   return 4'b0110;
         "xor":   return 4'b0111;
         default: return 4'b1111;
      endcase
   endfunction

   // Classify to a mnemonic first, then derive fields from the instruction class.
   function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p,
                                       input logic [31:0] r1, input logic [31:0] r2);
      exp_t        e;
      string       m;
      string       alu_names[8];
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm_i, imm_s, imm_u, sh;
      alu_names = '{"add", "sll", "ill", "sltu", "xor", "srl", "or", "and"};
      opc   = i[6:0];
      f3    = i[14:12];
      f7    = i[31:25];
      imm_i = {{20{i[31]}}, i[31:20]};
      imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
      imm_u = {i[31:12], 12'h000};
      sh    = {27'd0, i[24:20]};
      m     = "ill";
      if (opc == 7'h33) begin
         if (f7 == 7'h00) m = alu_names[f3];
         else if (f7 == 7'h20 && f3 == 3'd0) m = "sub";
         else if (f7 == 7'h01 && f3 == 3'd0) m = "mul";
      end else if (opc == 7'h13) begin
         m = alu_names[f3];
         if ((m == "sll" || m == "srl") && f7 != 7'h00) m = "ill";
      end else if (opc == 7'h03 && f3 == 3'd2) m = "lw";
      else if (opc == 7'h23 && f3 == 3'd2) m = "sw";
      else if (opc == 7'h63) begin
         if (f3 == 3'd0) m = "beq";
         if (f3 == 3'd1) m = "bne";
         if (f3 == 3'd6) m = "bltu";
         if (f3 == 3'd7) m = "bgeu";
      end else if (opc == 7'h37) m = "lui";
      else if (opc == 7'h17) m = "auipc";

      e = '{ctl: 4'b0010, a: 32'd0, b: 32'd0, rd: i[11:7], rw: 1'b0, mr: 1'b0,
             mw: 1'b0, sd: 32'd0, br: 1'b0, bi: 1'b0, ill: 1'b0};
      if (m == "ill") begin
         e.ill = 1'b1;
      end else if (opc == 7'h33) begin
         e.a = r1; e.b = r2; e.rw = 1'b1; e.ctl = code_of(m);
      end else if (opc == 7'h13) begin
         e.a = r1; e.b = (m == "sll" || m == "srl") ? sh : imm_i;
         e.rw = 1'b1; e.ctl = code_of(m);
      end else if (m == "lw") begin
         e.a = r1; e.b = imm_i; e.mr = 1'b1; e.rw = 1'b1;
      end else if (m == "sw") begin
         e.a = r1; e.b = imm_s; e.mw = 1'b1; e.sd = r2;
      end else if (opc == 7'h63) begin
         e.a = r1; e.b = r2; e.br = 1'b1;
         e.bi  = (m == "bne" || m == "bgeu");
         e.ctl = (m == "beq" || m == "bne") ? code_of("sub") : code_of("sltu");
      end else if (m == "lui") begin
         e.b = imm_u; e.rw = 1'b1;
      end else begin
         e.a = p; e.b = imm_u; e.rw = 1'b1;
      end
      if (e.rd == 5'd0) e.rw = 1'b0;
      return e;
   endfunction

   // One clock: drive just after posedge, check at negedge, advance the model.
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic fl, input logic o_rdy);
      bus.in_valid  = v;
      bus.instr     = ins;
      bus.pc        = p;
      bus.rs1_data  = r1;
      bus.rs2_data  = r2;
      bus.flush     = fl;
      bus.out_ready = o_rdy;
      @(negedge clk);
      check("out_valid", 32'(bus.out_valid), 32'(m_vld));
      check("in_ready", 32'(bus.in_ready), 32'(!m_vld || o_rdy));
      if (m_vld) begin
         check("alu_control", 32'(bus.alu_control), 32'(m_op.ctl));
         check("in1", bus.in1, m_op.a);
         check("in2", bus.in2, m_op.b);
         check("rd_addr", 32'(bus.rd_addr), 32'(m_op.rd));
         check("ctrl", {26'd0, bus.reg_write, bus.mem_read, bus.mem_write, bus.branch,
                        bus.branch_inv, bus.illegal},
               {26'd0, m_op.rw, m_op.mr, m_op.mw, m_op.br, m_op.bi, m_op.ill});
         check("store_data", bus.store_data, m_op.sd);
      end
      if (fl) m_vld = 1'b0;
      else if (v && (!m_vld || o_rdy)) begin
         m_vld = 1'b1;
         m_op  = ref_decode(ins, p, r1, r2);
      end else if (o_rdy) m_vld = 1'b0;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] opcs[8];
      logic [6:0] f7s[4];
      logic [6:0] opc, f7;
      logic [4:0] rd;
      opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h00};
      f7s  = '{7'h00, 7'h20, 7'h01, 7'h00};
      opc  = opcs[$urandom_range(7)];
      if (opc == 7'h00) opc = 7'($urandom);
      f7 = ($urandom_range(9) == 0) ? 7'($urandom) : f7s[$urandom_range(3)];
      rd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
      return {f7, 5'($urandom), 5'($urandom), 3'($urandom), rd, opc};
   endfunction

   logic [31:0] snap_in1, snap_in2;
   logic [3:0]  snap_ctl;

   initial begin
      n_vec = 0;
      n_bad = 0;
      m_vld = 1'b0;
      m_op  = ref_decode(32'd0, 32'd0, 32'd0, 32'd0);
      rst_n = 1'b1;
      bus.in_valid = 1'b0; bus.instr = 32'd0; bus.pc = 32'd0; bus.rs1_data = 32'd0;
      bus.rs2_data = 32'd0; bus.flush = 1'b0; bus.out_ready = 1'b1;

      // Asynchronous reset with no clock edge in between.
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_alu_control", 32'(bus.alu_control), 32'h2);
      check("rst_in1", bus.in1, 32'd0);
      check("rst_in2", bus.in2, 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // add x3,x1,x2
      step(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 1'b0, 1'b1);
      check("add_ctl", 32'(bus.alu_control), 32'h2);
      check("add_in1", bus.in1, 32'd5);
      check("add_in2", bus.in2, 32'd7);
      check("add_rd", 32'(bus.rd_addr), 32'd3);
      check("add_rw", 32'(bus.reg_write), 32'd1);
      // addi x1,x0,-1 then sub back-to-back
      step(1'b1, 32'hFFF00093, 32'h104, 32'd0, 32'd0, 1'b0, 1'b1);
      check("addi_in2", bus.in2, 32'hFFFFFFFF);
      step(1'b1, 32'h40208233, 32'h108, 32'd9, 32'd4, 1'b0, 1'b1);
      check("sub_ctl", 32'(bus.alu_control), 32'h4);
      check("sub_no_bubble", 32'(bus.out_valid), 32'd1);

      // Stall three cycles with a new op waiting.
      snap_ctl = bus.alu_control; snap_in1 = bus.in1; snap_in2 = bus.in2;
      for (int k = 0; k < 3; k++)
         step(1'b1, 32'h0020F1B3, 32'h10C, 32'd3, 32'd6, 1'b0, 1'b0);
      check("stall_ctl", 32'(bus.alu_control), 32'(snap_ctl));
      check("stall_in1", bus.in1, snap_in1);
      check("stall_in2", bus.in2, snap_in2);
      step(1'b1, 32'h0020F1B3, 32'h10C, 32'd3, 32'd6, 1'b0, 1'b1);
      check("after_stall_ctl", 32'(bus.alu_control), 32'h0);

      // Flush while holding and with a new op offered.
      step(1'b1, 32'h002081B3, 32'h110, 32'd1, 32'd1, 1'b0, 1'b0);
      step(1'b1, 32'h0020C1B3, 32'h114, 32'd2, 32'd2, 1'b1, 1'b0);
      check("flush_out_valid", 32'(bus.out_valid), 32'd0);
      step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);

      // slt (signed) is unsupported.
      step(1'b1, 32'h0020A1B3, 32'h118, 32'd8, 32'd9, 1'b0, 1'b1);
      check("slt_illegal", 32'(bus.illegal), 32'd1);
      check("slt_rw", 32'(bus.reg_write), 32'd0);
      check("slt_in1", bus.in1, 32'd0);

      // Reset mid-stall drops the held op.
      step(1'b1, 32'h00000037 | (32'd5 << 7), 32'h11C, 32'd0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midstall_rst_valid", 32'(bus.out_valid), 32'd0);
      check("midstall_rst_ctl", 32'(bus.alu_control), 32'h2);
      m_vld = 1'b0;
      #1 rst_n = 1'b1;
      step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

      // Random traffic.
      for (int n = 0; n < 3000; n++)
         step($urandom_range(3) != 0, rand_instr(), $urandom, $urandom, $urandom,
              $urandom_range(15) == 0, $urandom_range(9) < 7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
